// File: rtl/approx_wallace_mac_accumulator_if.sv
// approx_wallace_mac_accumulator_if: product-in / run-sum-out handshake bundle for the approximate MAC accumulator
interface approx_wallace_mac_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              busy;
  logic              overflow;
  modport master (
    output start, len, prod_valid, prod, acc_ready,
    input  prod_ready, acc_valid, acc_out, busy, overflow
  );
  modport slave (
    input  start, len, prod_valid, prod, acc_ready,
    output prod_ready, acc_valid, acc_out, busy, overflow
  );
endinterface

// File: rtl/approx_wallace_mac_accumulator.sv
// approx_wallace_mac_accumulator: accumulates a run of len approximate products and hands back the sum.
// Define ACC_SATURATE_EN to clamp at 2^ACC_W-1 on carry instead of wrapping.
module approx_wallace_mac_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst_n,
  approx_wallace_mac_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] remaining;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             xfer;
  logic             take_start;
  assign sum        = {1'b0, acc} + (ACC_W+1)'(bus.prod);
  assign xfer       = (state == ACCUM) && bus.prod_valid;
  assign take_start = (state == IDLE) && bus.start;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  always_comb begin
    state_nxt       = state;
    bus.prod_ready  = 1'b0;
    bus.acc_valid   = 1'b0;
    bus.busy        = state != IDLE;
    case (state)
      IDLE:    state_nxt = bus.start ? ((bus.len == '0) ? HOLD : ACCUM) : IDLE;
      ACCUM: begin
        bus.prod_ready = 1'b1;
        state_nxt      = (xfer && remaining == CNT_W'(1)) ? HOLD : ACCUM;
      end
      HOLD: begin
        bus.acc_valid = 1'b1;
        state_nxt     = bus.acc_ready ? IDLE : HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // Once saturated, any later non-zero product carries again, so the clamp holds for the rest of the run.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else if (take_start) begin
      acc       <= '0;
      remaining <= bus.len;
      ovf       <= 1'b0;
    end else if (xfer) begin
`ifdef ACC_SATURATE_EN
      acc       <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
      acc       <= sum[ACC_W-1:0];
`endif
      remaining <= remaining - CNT_W'(1);
      ovf       <= ovf | sum[ACC_W];
    end
  assign bus.acc_out  = acc;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_approx_wallace_mac_accumulator.sv
// tb_approx_wallace_mac_accumulator: directed checks of the accumulator on a 24-bit and a 16-bit instance.
module tb_approx_wallace_mac_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [6:0] pat;
  always #5 clk = ~clk;
  approx_wallace_mac_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) u_if ();
  approx_wallace_mac_accumulator_if #(.PROD_W(16), .ACC_W(16), .CNT_W(8)) w_if ();
  approx_wallace_mac_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if));
  approx_wallace_mac_accumulator #(.PROD_W(16), .ACC_W(16), .CNT_W(8)) w_dut (.clk(clk), .rst_n(rst_n), .bus(w_if));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    u_if.start = 0; u_if.len = 0; u_if.prod_valid = 0; u_if.prod = 0; u_if.acc_ready = 0;
    w_if.start = 0; w_if.len = 0; w_if.prod_valid = 0; w_if.prod = 0; w_if.acc_ready = 0;
    tick(); tick();
    chk("rst_acc", 32'(u_if.acc_out), 0);
    chk("rst_busy", 32'(u_if.busy), 0);
    chk("rst_prod_ready", 32'(u_if.prod_ready), 0);
    chk("rst_acc_valid", 32'(u_if.acc_valid), 0);
    chk("rst_overflow", 32'(u_if.overflow), 0);
    rst_n = 1; tick();
    // reset in the middle of a 4-product run
    u_if.start = 1; u_if.len = 4; tick();
    u_if.start = 0;
    chk("t1_busy", 32'(u_if.busy), 1);
    chk("t1_prod_ready", 32'(u_if.prod_ready), 1);
    u_if.prod_valid = 1; u_if.prod = 16'h0005; tick(); tick();
    u_if.prod_valid = 0;
    chk("t1_partial", 32'(u_if.acc_out), 32'h0A);
    #2 rst_n = 0; #1;
    chk("t1_async_acc", 32'(u_if.acc_out), 0);
    chk("t1_async_busy", 32'(u_if.busy), 0);
    chk("t1_async_valid", 32'(u_if.acc_valid), 0);
    rst_n = 1; tick();
    chk("t1_idle_after", 32'(u_if.busy), 0);
    // len=3 run
    u_if.start = 1; u_if.len = 3; tick();
    u_if.start = 0; u_if.len = 7;
    u_if.prod_valid = 1; u_if.prod = 16'h0010; tick();
    u_if.prod = 16'h0020; tick();
    u_if.prod = 16'h0030;
    chk("t2_no_early_valid", 32'(u_if.acc_valid), 0);
    tick();
    u_if.prod_valid = 0;
    chk("t2_valid", 32'(u_if.acc_valid), 1);
    chk("t2_sum", 32'(u_if.acc_out), 32'h60);
    chk("t2_ovf", 32'(u_if.overflow), 0);
    chk("t2_hold_ready", 32'(u_if.prod_ready), 0);
    u_if.acc_ready = 1; tick();
    u_if.acc_ready = 0;
    chk("t2_idle_valid", 32'(u_if.acc_valid), 0);
    chk("t2_idle_busy", 32'(u_if.busy), 0);
    chk("t2_retained", 32'(u_if.acc_out), 32'h60);
    // empty run
    u_if.start = 1; u_if.len = 0;
    chk("t3_ready_idle", 32'(u_if.prod_ready), 0);
    tick();
    u_if.start = 0;
    chk("t3_valid", 32'(u_if.acc_valid), 1);
    chk("t3_sum", 32'(u_if.acc_out), 0);
    chk("t3_ready_hold", 32'(u_if.prod_ready), 0);
    u_if.acc_ready = 1; tick();
    u_if.acc_ready = 0;
    chk("t3_idle", 32'(u_if.busy), 0);
    chk("t3_ready_after", 32'(u_if.prod_ready), 0);
    // stalled producer and stalled consumer
    u_if.start = 1; u_if.len = 4; tick();
    u_if.start = 0;
    pat = 7'b1011001;
    u_if.prod = 16'hFFFF;
    for (int i = 0; i < 7; i++) begin
      u_if.prod_valid = pat[i];
      tick();
      if (i == 5) chk("t4_not_done", 32'(u_if.acc_valid), 0);
    end
    u_if.prod_valid = 0;
    chk("t4_valid", 32'(u_if.acc_valid), 1);
    chk("t4_sum", 32'(u_if.acc_out), 32'h03FFFC);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_valid", 32'(u_if.acc_valid), 1);
      chk("t4_stall_sum", 32'(u_if.acc_out), 32'h03FFFC);
    end
    u_if.acc_ready = 1; tick();
    u_if.acc_ready = 0;
    chk("t4_idle", 32'(u_if.busy), 0);
    // carry out of a 16-bit accumulator
    w_if.start = 1; w_if.len = 2; tick();
    w_if.start = 0;
    w_if.prod_valid = 1; w_if.prod = 16'hFFFF; tick();
    w_if.prod = 16'h0002; tick();
    w_if.prod_valid = 0;
    chk("t5_valid", 32'(w_if.acc_valid), 1);
`ifdef ACC_SATURATE_EN
    chk("t5_sum", 32'(w_if.acc_out), 32'hFFFF);
`else
    chk("t5_sum", 32'(w_if.acc_out), 32'h0001);
`endif
    chk("t5_ovf", 32'(w_if.overflow), 1);
    w_if.acc_ready = 1; tick();
    w_if.acc_ready = 0;
    chk("t5_ovf_sticky", 32'(w_if.overflow), 1);
    // starts outside IDLE are ignored; overflow clears on an accepted start
    w_if.start = 1; w_if.len = 2; tick();
    w_if.start = 0;
    chk("t6_ovf_clear", 32'(w_if.overflow), 0);
    w_if.prod_valid = 1; w_if.prod = 16'h0003; w_if.start = 1; w_if.len = 0; tick();
    w_if.start = 0; w_if.prod = 16'h0004; tick();
    w_if.prod_valid = 0;
    chk("t6_valid", 32'(w_if.acc_valid), 1);
    chk("t6_sum", 32'(w_if.acc_out), 32'h7);
    w_if.acc_ready = 1; w_if.start = 1; w_if.len = 1; tick();
    w_if.acc_ready = 0; w_if.start = 0;
    chk("t6_idle_busy", 32'(w_if.busy), 0);
    chk("t6_idle_valid", 32'(w_if.acc_valid), 0);
    tick();
    chk("t6_still_idle", 32'(w_if.busy), 0);
    chk("t6_kept", 32'(w_if.acc_out), 32'h7);
    w_if.start = 1; w_if.len = 1; tick();
    w_if.start = 0;
    chk("t6_restart_busy", 32'(w_if.busy), 1);
    chk("t6_restart_acc", 32'(w_if.acc_out), 0);
    w_if.prod_valid = 1; w_if.prod = 16'h0009; tick();
    w_if.prod_valid = 0;
    chk("t6_run2_valid", 32'(w_if.acc_valid), 1);
    chk("t6_run2_sum", 32'(w_if.acc_out), 32'h9);
    chk("t6_run2_ovf", 32'(w_if.overflow), 0);
    w_if.acc_ready = 1; tick();
    w_if.acc_ready = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
